// File: rtl/sevseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sevseg_scan_ctrl
//   N-digit multiplexed seven-segment display controller. It handles hex
//   decode, time-multiplexed anode scan, per-digit decimal points,
//   leading-zero blanking, PWM brightness, a dead time at the start of each
//   slot (anti-ghosting) and tear-free shadow loading of the displayed value.
//
// Ports
//   clk_i        in   system clock
//   rst_i        in   synchronous reset, active-high
//   data_i       in   hex nibbles, digit 0 = data_i[3:0] (rightmost)
//   dp_i         in   decimal point per digit, 1 = lit
//   load_i       in   1-cycle strobe, captures data_i/dp_i into pending
//   digit_en_i   in   per-digit enable, 0 = digit dark (sampled live)
//   blank_lz_i   in   1 = blank leading zero digits (sampled live)
//   bright_i     in   brightness 0 (off) .. 15 (full) (sampled live)
//   en_o         out  anode drives, one-hot or none, in anode polarity
//   seg_o        out  cathodes {g,f,e,d,c,b,a}, in segment polarity
//   dp_o         out  decimal point cathode, in segment polarity
//   frame_o      out  1-cycle pulse on the frame wrap cycle
// ---------------------------------------------------------------------------
module sevseg_scan_ctrl #(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int DEAD_CYC       = 4,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  blank_lz_i,
  input  logic [3:0]            bright_i,
  output logic [N_DIGITS-1:0]   en_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int SCW = $clog2(REFRESH_DIV);  // slot counter width
  localparam int LW  = SCW + 1;              // wide enough to hold REFRESH_DIV
  localparam int SW  = $clog2(N_DIGITS);     // digit select width

  localparam logic [SCW-1:0] SLOT_MAX = SCW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0]  SEL_MAX  = SW'(N_DIGITS - 1);
  localparam logic [LW-1:0]  DEAD_LIM = LW'(DEAD_CYC);
  localparam logic [LW-1:0]  FULL_LIM = LW'(REFRESH_DIV);
  localparam logic [LW-1:0]  SLICE_L  = LW'(REFRESH_DIV / 16);

  localparam logic               AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic               SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] EN_OFF  = {N_DIGITS{AN_INV}};
  localparam logic [6:0]          SEG_OFF = {7{SEG_INV}};

  // Active-high gfedcba pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [SCW-1:0]        r_slot_cnt;
  logic [SW-1:0]         r_sel;
  logic                  r_frame;

  // Shadow registers: pending collects loads, active is what is displayed
  logic [4*N_DIGITS-1:0] r_pend_data;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic [4*N_DIGITS-1:0] r_act_data;
  logic [N_DIGITS-1:0]   r_act_dp;

  // Registered pin drives
  logic [N_DIGITS-1:0]   r_en;
  logic [6:0]            r_seg;
  logic                  r_dp;

  // Combinational next values
  logic [SCW-1:0]        w_slot_cnt_next;
  logic [SW-1:0]         w_sel_next;
  logic                  w_frame_next;
  logic [N_DIGITS:0]     w_zero_from;
  logic [N_DIGITS-1:0]   w_lz_blank;
  logic [N_DIGITS-1:0]   w_vis;
  logic [LW-1:0]         w_on_lim;
  logic                  w_in_window;
  logic                  w_lit;
  logic [3:0]            w_nibble;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [N_DIGITS-1:0]   w_en_next;
  logic [6:0]            w_seg_next;
  logic                  w_dp_next;

  // Slot counter and digit select advance
  always_comb begin
    w_slot_cnt_next = r_slot_cnt + 1'b1;
    w_sel_next      = r_sel;
    if (r_slot_cnt == SLOT_MAX) begin
      w_slot_cnt_next = '0;
      w_sel_next      = (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
    end
  end

  // frame_o is precomputed one cycle early so it is high exactly while the
  // scan sits on the last cycle of the last digit, i.e. the wrap cycle.
  assign w_frame_next = (w_slot_cnt_next == SLOT_MAX) && (w_sel_next == SEL_MAX);

  // w_zero_from[i] = 1 when active nibbles i..N_DIGITS-1 are all zero.
  assign w_zero_from[N_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign w_zero_from[gi] = (r_act_data[4*gi +: 4] == 4'h0) && w_zero_from[gi+1];
    if (gi == 0) begin : g_first
      // The rightmost digit always shows, so a zero value still reads "0".
      assign w_lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_lz_blank[gi] = blank_lz_i && w_zero_from[gi];
    end
  end

  assign w_vis = digit_en_i & ~w_lz_blank;

  // Lit window inside a slot: DEAD_CYC <= slot_cnt < on limit.
  // Full brightness stretches to the end of the slot instead of 15/16.
  assign w_on_lim    = (bright_i == 4'hF) ? FULL_LIM : LW'(bright_i) * SLICE_L;
  assign w_in_window = ({1'b0, r_slot_cnt} >= DEAD_LIM) && ({1'b0, r_slot_cnt} < w_on_lim);
  assign w_lit       = w_in_window && w_vis[r_sel];
  assign w_nibble    = r_act_data[{r_sel, 2'b00} +: 4];

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_sel] = 1'b1;
    w_en_next       = (w_lit ? w_onehot : '0) ^ EN_OFF;
    w_seg_next      = (w_lit ? hex_to_seg(w_nibble) : 7'h00) ^ SEG_OFF;
    w_dp_next       = (w_lit && r_act_dp[r_sel]) ^ SEG_INV;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_slot_cnt  <= '0;
      r_sel       <= '0;
      r_frame     <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_en        <= EN_OFF;
      r_seg       <= SEG_OFF;
      r_dp        <= SEG_INV;
    end else begin
      r_slot_cnt <= w_slot_cnt_next;
      r_sel      <= w_sel_next;
      r_frame    <= w_frame_next;

      if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
      end

      // Active only changes at the frame wrap so a frame never mixes two
      // values. A load landing on the wrap cycle bypasses pending.
      if (r_frame) begin
        r_act_data <= load_i ? data_i : r_pend_data;
        r_act_dp   <= load_i ? dp_i   : r_pend_dp;
      end

      // Anode and cathodes update on the same edge, so segments never
      // change under a lit anode.
      r_en  <= w_en_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign en_o    = r_en;
  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sevseg_scan_ctrl
//   Self-checking bench for sevseg_scan_ctrl with 4 digits, 32-cycle slots,
//   2 dead cycles, active-low anodes and segments. A table of vectors is
//   checked cycle by cycle over a whole frame; hand-written sequences cover
//   shadow loading, load on the wrap cycle and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_sevseg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 32;
  localparam int DC = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [15:0]   data_i;
  logic [3:0]    dp_i;
  logic          load_i;
  logic [3:0]    digit_en_i;
  logic          blank_lz_i;
  logic [3:0]    bright_i;
  logic [3:0]    en_o;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic          frame_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  sevseg_scan_ctrl #(
    .N_DIGITS      (N),
    .REFRESH_DIV   (RD),
    .DEAD_CYC      (DC),
    .AN_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .digit_en_i(digit_en_i),
    .blank_lz_i(blank_lz_i),
    .bright_i  (bright_i),
    .en_o      (en_o),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .frame_o   (frame_o)
  );

  // Inputs plus hand-computed expectations for one frame.
  // seg/dpo are active-low values per digit when that digit is lit;
  // the digit is lit for slot cycles lo <= c < hi when lit[s] = 1.
  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      den;
    logic            blz;
    logic [3:0]      bright;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
    int              lo;
    int              hi;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] e_en,
                            input logic [6:0] e_seg, input logic e_dp);
    check({name, " en"},  {3'b000, en_o},  {3'b000, e_en});
    check({name, " seg"}, seg_o,           e_seg);
    check({name, " dp"},  {6'b0, dp_o},    {6'b0, e_dp});
  endtask

  // Returns at the negedge on which frame_o is seen high.
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (frame_o) begin
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_wait: frame_o not seen within 300 cycles, expected a pulse every %0d", N*RD);
  endtask

  // Lands on the negedge where the outputs show frame index j (index 0 =
  // digit 0, slot cycle 0) of the frame following the next wrap.
  task automatic sync_out(input int j);
    bit ok;
    wait_frame(ok);
    repeat (j + 2) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_i = d;
    dp_i   = p;
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    bit         ok;
    int         s, c;
    bit         on;
    logic [3:0] oh;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    wait_frame(ok);
    if (!ok) return;
    @(posedge clk_i);
    @(posedge clk_i);
    for (int j = 0; j < N*RD; j++) begin
      if (j > 0) @(posedge clk_i);
      @(negedge clk_i);
      s     = j / RD;
      c     = j % RD;
      on    = v.lit[s] && (c >= v.lo) && (c < v.hi);
      oh    = 4'b0001 << s;
      e_en  = on ? ~oh : 4'hF;
      e_seg = on ? v.seg[s] : 7'h7F;
      e_dp  = on ? v.dpo[s] : 1'b1;
      check_outs($sformatf("vec%0d slot%0d cyc%0d", vi, s, c), e_en, e_seg, e_dp);
      check($sformatf("vec%0d frame_o idx%0d", vi, j), {6'b0, frame_o}, {6'b0, (j == N*RD-2)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           data      dp       den    blz   bri    lit      seg {d3,d2,d1,d0}                dpo      lo  hi
    vecs[0]  = '{16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd15, 4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF,    2, 32};
    vecs[1]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, 4'd15, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF,    2, 32};
    vecs[2]  = '{16'h0000, 4'b0000, 4'hF, 1'b1, 4'd15, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF,    2, 32};
    vecs[3]  = '{16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd4,  4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF,    2, 8};
    vecs[4]  = '{16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd1,  4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF,    2, 2};
    vecs[5]  = '{16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd0,  4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF,    2, 0};
    vecs[6]  = '{16'h3C5D, 4'b0100, 4'b1011, 1'b0, 4'd15, 4'b1011, {7'h30, 7'h46, 7'h12, 7'h21}, 4'hF, 2, 32};
    vecs[7]  = '{16'h3C5D, 4'b0100, 4'hF, 1'b0, 4'd15, 4'b1111, {7'h30, 7'h46, 7'h12, 7'h21}, 4'b1011, 2, 32};
    vecs[8]  = '{16'h0007, 4'b1000, 4'hF, 1'b1, 4'd15, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'hF,    2, 32};
    vecs[9]  = '{16'h9086, 4'b0001, 4'hF, 1'b1, 4'd8,  4'b1111, {7'h10, 7'h40, 7'h00, 7'h02}, 4'b1110, 2, 16};
    vecs[10] = '{16'h4BE0, 4'b0000, 4'hF, 1'b0, 4'd14, 4'b1111, {7'h19, 7'h03, 7'h06, 7'h40}, 4'hF,    2, 28};

    rst_i      = 1'b1;
    load_i     = 1'b0;
    data_i     = 16'h0000;
    dp_i       = 4'b0000;
    digit_en_i = 4'hF;
    blank_lz_i = 1'b0;
    bright_i   = 4'd15;
    repeat (3) @(negedge clk_i);
    check_outs("reset", 4'hF, 7'h7F, 1'b1);
    check("reset frame_o", {6'b0, frame_o}, 7'h00);
    $display("reset checked: en=%b seg=%h dp=%b frame=%b", en_o, seg_o, dp_o, frame_o);
    rst_i = 1'b0;

    for (int vi = 0; vi < 11; vi++) begin
      digit_en_i = vecs[vi].den;
      blank_lz_i = vecs[vi].blz;
      bright_i   = vecs[vi].bright;
      do_load(vecs[vi].data, vecs[vi].dp);
      run_frame(vecs[vi], vi);
      $display("vec %0d: data=%h dp=%b den=%b blz=%b bright=%0d checked over one frame",
               vi, vecs[vi].data, vecs[vi].dp, vecs[vi].den, vecs[vi].blz, vecs[vi].bright);
    end

    // Shadow loading: two loads mid-frame, display holds until the wrap.
    digit_en_i = 4'hF;
    blank_lz_i = 1'b0;
    bright_i   = 4'd15;
    do_load(16'h5555, 4'b0000);
    sync_out(40);
    do_load(16'h1111, 4'b0000);
    repeat (20) @(negedge clk_i);
    do_load(16'h2222, 4'b0000);
    repeat (8) @(negedge clk_i);
    check_outs("shadow hold slot2", 4'b1011, 7'h12, 1'b1);
    sync_out(2);
    check_outs("shadow swap slot0", 4'b1110, 7'h24, 1'b1);
    $display("shadow: loads 1111 then 2222 mid-frame, en=%b seg=%h after wrap", en_o, seg_o);

    // Load on the frame_o cycle goes straight to active.
    begin
      bit ok;
      wait_frame(ok);
      do_load(16'h7777, 4'b0000);
      repeat (3) @(negedge clk_i);
      check_outs("load on wrap slot0", 4'b1110, 7'h78, 1'b1);
      $display("load on wrap: en=%b seg=%h", en_o, seg_o);
    end

    // Reset in slot 2 aborts the scan and clears the shadow registers.
    sync_out(70);
    check_outs("pre-reset slot2", 4'b1011, 7'h78, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_outs("mid-frame reset", 4'hF, 7'h7F, 1'b1);
    check("mid-frame reset frame_o", {6'b0, frame_o}, 7'h00);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_outs("post-reset slot0", 4'b1110, 7'h40, 1'b1);
    repeat (32) @(negedge clk_i);
    check_outs("post-reset slot1", 4'b1101, 7'h40, 1'b1);
    $display("reset mid-frame: scan restarted, en=%b seg=%h", en_o, seg_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
